// File: rtl/brick_pkg.sv
// Shared types and constants for the brick tile matrix hit path.
package brick_pkg;

  localparam int unsigned MATRIX_COLS = 17;
  localparam int unsigned MATRIX_ROWS = 14;
  localparam int unsigned TILE_X_W    = 5;
  localparam int unsigned TILE_Y_W    = 4;

  typedef logic [TILE_X_W-1:0] tile_x_t;
  typedef logic [TILE_Y_W-1:0] tile_y_t;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} arb_state_t;

  // True when the tile lies inside a cols x rows matrix.
  function automatic logic tile_in_range(tile_x_t x, tile_y_t y,
                                         int unsigned cols, int unsigned rows);
    return (32'(x) < cols) && (32'(y) < rows);
  endfunction

endpackage

// File: rtl/brick_hit_arbiter_rr_pick.sv
// Round-robin priority encoder: first pending bit at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  pending,
  input  logic [PW-1:0] ptr,
  output logic          found_c,
  output logic [PW-1:0] winner_c
);

  // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1].
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found_c && pending[i] && (i >= int'(ptr))) begin
        found_c  = 1'b1;
        winner_c = PW'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found_c && pending[i]) begin
        found_c  = 1'b1;
        winner_c = PW'(i);
      end
    end
  end

endmodule

// File: rtl/brick_hit_arbiter.sv
// Serialises brick hits from several requesters into clean single-port collision pulses
// with a guaranteed high time and low gap between hits.
module brick_hit_arbiter
  import brick_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned COLS        = MATRIX_COLS,
  parameter int unsigned ROWS        = MATRIX_ROWS,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  tile_x_t [NUM_REQ-1:0] req_x,
  input  tile_y_t [NUM_REQ-1:0] req_y,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  collision,
  output tile_x_t               brickCollision1X,
  output tile_y_t               brickCollision1Y,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic                  range_err
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = 4;

  arb_state_t state_q, state_d;

  logic [NUM_REQ-1:0]    pend_q, pend_d;
  tile_x_t [NUM_REQ-1:0] slot_x_q, slot_x_d;
  tile_y_t [NUM_REQ-1:0] slot_y_q, slot_y_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  collision_q, collision_d;
  tile_x_t               x_q, x_d;
  tile_y_t               y_q, y_d;
  logic [2:0]            grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  range_err_q, range_err_d;

  logic                  found_c;
  logic [PW-1:0]         winner_c;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .pending  (pend_q),
    .ptr      (rr_ptr_q),
    .found_c  (found_c),
    .winner_c (winner_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found_c)        state_d = HOLD;
      HOLD:    if (cnt_q == '0)    state_d = GAP;
      GAP:     if (cnt_q == '0)    state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Slot loading, grant bookkeeping and output register next values.
  always_comb begin
    pend_d      = pend_q;
    slot_x_d    = slot_x_q;
    slot_y_d    = slot_y_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    collision_d = collision_q;
    x_d         = x_q;
    y_d         = y_q;
    grant_d     = grant_q;
    range_err_d = 1'b0;

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[i] && !pend_q[i]) begin
        if (tile_in_range(req_x[i], req_y[i], COLS, ROWS)) begin
          pend_d[i]   = 1'b1;
          slot_x_d[i] = req_x[i];
          slot_y_d[i] = req_y[i];
        end else begin
          range_err_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        collision_d = 1'b0;
        if (found_c) begin
          pend_d[winner_c] = 1'b0;
          collision_d      = 1'b1;
          x_d              = slot_x_q[winner_c];
          y_d              = slot_y_q[winner_c];
          grant_d          = 3'(winner_c);
          cnt_d            = CW'(HOLD_CYCLES - 1);
          if (winner_c == PW'(NUM_REQ - 1)) rr_ptr_d = '0;
          else                              rr_ptr_d = winner_c + PW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          collision_d = 1'b0;
          cnt_d       = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        collision_d = 1'b0;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: collision_d = 1'b0;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q      <= '0;
      slot_x_q    <= '0;
      slot_y_q    <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      collision_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      slot_x_q    <= slot_x_d;
      slot_y_q    <= slot_y_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      collision_q <= collision_d;
      x_q         <= x_d;
      y_q         <= y_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      range_err_q <= range_err_d;
    end
  end

  assign req_ready        = ~pend_q;
  assign collision        = collision_q;
  assign brickCollision1X = x_q;
  assign brickCollision1Y = y_q;
  assign grant_id         = grant_q;
  assign busy             = busy_q;
  assign range_err        = range_err_q;

endmodule

// File: tb/tb_brick_hit_arbiter.sv
// Random and directed checks of brick_hit_arbiter against a time-since-grant reference model.
module tb_brick_hit_arbiter;

  localparam int N = 4;
  localparam int H = 1;
  localparam int G = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0][4:0] req_x = '0;
  logic [N-1:0][3:0] req_y = '0;

  logic [N-1:0] req_ready, h4_ready;
  logic         collision, h4_coll;
  logic [4:0]   bx, h4_x;
  logic [3:0]   by, h4_y;
  logic [2:0]   grant_id, h4_gid;
  logic         busy, h4_busy;
  logic         range_err, h4_rerr;

  brick_hit_arbiter u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .collision(collision), .brickCollision1X(bx),
    .brickCollision1Y(by), .grant_id(grant_id), .busy(busy), .range_err(range_err)
  );

  brick_hit_arbiter #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) u_dut_h4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(h4_ready), .collision(h4_coll), .brickCollision1X(h4_x),
    .brickCollision1Y(h4_y), .grant_id(h4_gid), .busy(h4_busy), .range_err(h4_rerr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending table plus age = cycles since the current grant (0 = idle).
  bit m_pend[N];
  int m_px[N], m_py[N];
  int m_rr, m_age, m_x, m_y, m_gid;
  bit m_rerr;

  int cyc = 0;
  bit coll_prev = 1'b0;
  int gq[$];
  int tq[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0; m_px[i] = 0; m_py[i] = 0;
    end
    m_rr = 0; m_age = 0; m_x = 0; m_y = 0; m_gid = 0; m_rerr = 1'b0;
  endtask

  task automatic model_edge();
    int w = -1;
    if (m_age == 0) begin
      for (int k = 0; k < N; k++) begin
        int idx = (m_rr + k) % N;
        if (w < 0 && m_pend[idx]) w = idx;
      end
    end else begin
      m_age++;
      if (m_age > H + G) m_age = 0;
    end
    if (w >= 0) begin
      m_x = m_px[w]; m_y = m_py[w]; m_gid = w;
      m_rr = (w + 1) % N; m_age = 1;
    end
    m_rerr = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !m_pend[i]) begin
        if (int'(req_x[i]) < 17 && int'(req_y[i]) < 14) begin
          m_pend[i] = 1'b1; m_px[i] = int'(req_x[i]); m_py[i] = int'(req_y[i]);
        end else begin
          m_rerr = 1'b1;
        end
      end
    end
    if (w >= 0) m_pend[w] = 1'b0;
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) exp_rdy[i] = ~m_pend[i];
    check_eq("collision", 32'(collision), 32'(m_age >= 1 && m_age <= H));
    check_eq("busy", 32'(busy), 32'(m_age != 0));
    check_eq("x", 32'(bx), 32'(m_x));
    check_eq("y", 32'(by), 32'(m_y));
    check_eq("grant_id", 32'(grant_id), 32'(m_gid));
    check_eq("range_err", 32'(range_err), 32'(m_rerr));
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
    if (collision && !coll_prev) begin
      gq.push_back(int'(grant_id));
      tq.push_back(cyc);
    end
    coll_prev = collision;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    coll_prev = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    gq.delete();
    tq.delete();
  endtask

  initial begin
    // 1: single hit
    do_reset();
    req_valid = 4'b0001; req_x[0] = 5'd3; req_y[0] = 4'd5;
    step();
    req_valid = '0;
    check_eq("t1_ready_low", 32'(req_ready[0]), 32'd0);
    step();
    check_eq("t1_coll", 32'(collision), 32'd1);
    check_eq("t1_x", 32'(bx), 32'd3);
    check_eq("t1_y", 32'(by), 32'd5);
    step();
    check_eq("t1_gap", 32'(collision), 32'd0);
    step();
    check_eq("t1_idle", 32'(busy), 32'd0);

    // 2: four simultaneous requests
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin req_x[i] = 5'(i); req_y[i] = 4'd0; end
    step();
    req_valid = '0;
    repeat (14) step();
    check_eq("t2_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) check_eq("t2_order", 32'(gq[i]), 32'(i));
    for (int i = 1; i < 4 && i < tq.size(); i++) check_eq("t2_period", 32'(tq[i] - tq[i-1]), 32'd3);

    // 3: fairness with two permanent requesters
    do_reset();
    req_valid = 4'b0110;
    req_x[1] = 5'd4; req_y[1] = 4'd4; req_x[2] = 5'd9; req_y[2] = 4'd9;
    repeat (30) step();
    req_valid = '0;
    repeat (6) step();
    check_eq("t3_count_ge8", 32'(gq.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < gq.size(); i++) check_eq("t3_alt", 32'(gq[i]), 32'((i % 2) + 1));

    // 4: out-of-range requests
    do_reset();
    req_valid = 4'b0011;
    req_x[0] = 5'd17; req_y[0] = 4'd2; req_x[1] = 5'd4; req_y[1] = 4'd14;
    step();
    req_valid = '0;
    check_eq("t4_rerr", 32'(range_err), 32'd1);
    check_eq("t4_ready", 32'(req_ready), 32'hF);
    step();
    check_eq("t4_rerr_once", 32'(range_err), 32'd0);
    repeat (4) step();
    check_eq("t4_no_pulse", 32'(gq.size()), 32'd0);

    // 5: two requesters on the same tile
    do_reset();
    req_valid = 4'b0101;
    req_x[0] = 5'd7; req_y[0] = 4'd3; req_x[2] = 5'd7; req_y[2] = 4'd3;
    step();
    req_valid = '0;
    repeat (8) step();
    check_eq("t5_count", 32'(gq.size()), 32'd2);
    if (tq.size() == 2) check_eq("t5_spacing", 32'(tq[1] - tq[0]), 32'(H + G + 1));

    // Long hold / gap pulse shape on the HOLD=4, GAP=2 instance
    do_reset();
    req_valid = 4'b0100; req_x[2] = 5'd5; req_y[2] = 4'd6;
    step();
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq("h4_coll", 32'(h4_coll), 32'(k < 4));
      check_eq("h4_busy", 32'(h4_busy), 32'(k < 6));
      if (k < 4) check_eq("h4_x", 32'(h4_x), 32'd5);
    end

    // 6: reset asserted in the middle of a 4-cycle hold
    do_reset();
    req_valid = 4'b0011;
    req_x[0] = 5'd1; req_y[0] = 4'd1; req_x[1] = 5'd2; req_y[1] = 4'd2;
    step();
    req_valid = '0;
    step();
    check_eq("t6_coll_on", 32'(h4_coll), 32'd1);
    step();
    check_eq("t6_still_on", 32'(h4_coll), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("t6_coll_drop", 32'(h4_coll), 32'd0);
    check_eq("t6_ready", 32'(h4_ready), 32'hF);
    check_eq("t6_busy", 32'(h4_busy), 32'd0);
    compare_all();
    coll_prev = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("t6_no_pulse", 32'(h4_coll), 32'd0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 35);
        req_x[i] = 5'($urandom_range(0, 18));
        req_y[i] = 4'($urandom_range(0, 15));
      end
      step();
    end
    req_valid = '0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
